// File: rtl/drv_ad56x3_arb_pkg.sv
// +--------------------------------------------------------------------+
// | drvAd56x3Pkg : shared FSM state type and channel codes.             |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package drvAd56x3Pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Round-robin pick: a lone pending slot wins, a tie goes to the channel not served last.
  function automatic logic pick_channel(input logic pend_a, input logic pend_b, input logic last_ch);
    logic grant;
    if (pend_a && pend_b) begin
      grant = ~last_ch;
    end else if (pend_a) begin
      grant = CH_A;
    end else begin
      grant = CH_B;
    end
    return grant;
  endfunction

endpackage

`default_nettype wire

// File: rtl/drv_ad56x3_arb_slot.sv
// +--------------------------------------------------------------------+
// | drv_ad56x3_slot : one-deep holding register with load/clear/pend.   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module drv_ad56x3_slot #(
  parameter int DATA_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_rdy,
  input  logic                  i_clr,
  output logic                  o_pend,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_load;

  // A load can only happen while empty and a clear only while full, so they never collide.
  assign w_load = i_valid & ~r_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_load) begin
        r_pend <= 1'b1;
        r_data <= i_data;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_rdy  = ~r_pend;
  assign o_pend = r_pend;
  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/drv_ad56x3_arb.sv
// +--------------------------------------------------------------------+
// | drv_ad56x3_arb : two-channel sample arbiter feeding an AD56x3 driver.|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module drv_ad56x3_arb
  import drvAd56x3Pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter bit PAIRED     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  snkValidA,
  input  logic [DATA_WIDTH-1:0] snkDataA,
  output logic                  snkRdyA,
  input  logic                  snkValidB,
  input  logic [DATA_WIDTH-1:0] snkDataB,
  output logic                  snkRdyB,
  output logic                  srcValid,
  output logic                  srcChannel,
  output logic [DATA_WIDTH-1:0] srcData,
  input  logic                  srcRdy,
  output logic                  pendA,
  output logic                  pendB,
  output logic                  busy
);

  logic                  w_pend_a;
  logic                  w_pend_b;
  logic [DATA_WIDTH-1:0] w_data_a;
  logic [DATA_WIDTH-1:0] w_data_b;
  logic                  w_clr_a;
  logic                  w_clr_b;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ch;
  logic                  w_ch_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  r_last;
  logic                  w_last_nxt;
  logic                  w_grant;

  drv_ad56x3_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_a (
    .clk    (clk),
    .reset  (reset),
    .i_valid(snkValidA),
    .i_data (snkDataA),
    .o_rdy  (snkRdyA),
    .i_clr  (w_clr_a),
    .o_pend (w_pend_a),
    .o_data (w_data_a)
  );

  drv_ad56x3_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_b (
    .clk    (clk),
    .reset  (reset),
    .i_valid(snkValidB),
    .i_data (snkDataB),
    .o_rdy  (snkRdyB),
    .i_clr  (w_clr_b),
    .o_pend (w_pend_b),
    .o_data (w_data_b)
  );

  assign w_grant = pick_channel(w_pend_a, w_pend_b, r_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ch    <= CH_A;
      r_data  <= '0;
      r_last  <= CH_B;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    w_clr_a     = 1'b0;
    w_clr_b     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (PAIRED) begin
          // Coherent mode waits for a full pair and always leads with A.
          if (w_pend_a && w_pend_b) begin
            w_state_nxt = ST_ISSUE;
            w_ch_nxt    = CH_A;
            w_data_nxt  = w_data_a;
            w_last_nxt  = CH_A;
          end
        end else if (w_pend_a || w_pend_b) begin
          w_state_nxt = ST_ISSUE;
          w_ch_nxt    = w_grant;
          w_data_nxt  = (w_grant == CH_B) ? w_data_b : w_data_a;
          w_last_nxt  = w_grant;
        end
      end
      ST_ISSUE: begin
        if (srcRdy) begin
          w_clr_a = (r_ch == CH_A);
          w_clr_b = (r_ch == CH_B);
          // B's slot cannot drain while A is in flight, so it is still valid here.
          if (PAIRED && (r_ch == CH_A)) begin
            w_ch_nxt   = CH_B;
            w_data_nxt = w_data_b;
            w_last_nxt = CH_B;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign srcValid   = (r_state == ST_ISSUE);
  assign srcChannel = r_ch;
  assign srcData    = r_data;
  assign pendA      = w_pend_a;
  assign pendB      = w_pend_b;
  assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire
